// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-operated vending controller with credit, per-item stock and change return
module vend_ctrl #(
  parameter int CREDIT_W   = 6,
  parameter int PRICE_0    = 3,
  parameter int PRICE_1    = 4,
  parameter int PRICE_2    = 5,
  parameter int PRICE_3    = 6,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic [1:0]          sel,
  input  logic                buy,
  input  logic                restock,
  output logic                drink,
  output logic [1:0]          item,
  output logic [1:0]          back,
  output logic                reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          sold_out
);
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
  localparam int CW1 = CREDIT_W + 1;
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0] stock_q [4];
  logic [STOCK_W-1:0] stock_d [4];
  logic [1:0] item_q, item_d;
  logic reject_q, reject_d;
  logic [CW1-1:0] sum, price;
  logic ge2;
  // One extra bit on the sum exposes credit overflow instead of wrapping
  assign sum = {1'b0, credit_q} + CW1'(coin);
  assign ge2 = |credit_q[CREDIT_W-1:1];
  // Price of the currently selected item
  always_comb begin
    price = sel == 2'd0 ? CW1'(PRICE_0) :
            sel == 2'd1 ? CW1'(PRICE_1) :
            sel == 2'd2 ? CW1'(PRICE_2) : CW1'(PRICE_3);
  end
  // Next-state logic: coin/buy handling in IDLE, one-cycle vend, change payout
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    item_d   = item_q;
    reject_d = 1'b0;
    if (state_q == IDLE) begin
      if (coin == 2'b11) begin
        state_d = |credit_q ? CHANGE : IDLE;
      end else if (coin != 2'b00) begin
        reject_d = sum[CREDIT_W];
        credit_d = sum[CREDIT_W] ? credit_q : sum[CREDIT_W-1:0];
      end else if (buy) begin
        if ({1'b0, credit_q} >= price && |stock_q[sel]) begin
          credit_d     = credit_q - price[CREDIT_W-1:0];
          stock_d[sel] = stock_q[sel] - STOCK_W'(1);
          item_d       = sel;
          state_d      = VEND;
        end else begin
          reject_d = 1'b1;
        end
      end
    end else begin
      reject_d = |coin;
      if (state_q == VEND) begin
        state_d = |credit_q ? CHANGE : IDLE;
      end else begin
        credit_d = credit_q - (ge2 ? CREDIT_W'(2) : CREDIT_W'(1));
        state_d  = credit_d == '0 ? IDLE : CHANGE;
      end
    end
    if (restock) for (int i = 0; i < 4; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
  end
  // State, credit, stock and pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      item_q   <= '0;
      reject_q <= 1'b0;
      for (int i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      reject_q <= reject_d;
      stock_q  <= stock_d;
    end
  end
  // Moore outputs decoded from registered state
  always_comb begin
    drink  = state_q == VEND;
    item   = state_q == VEND ? item_q : 2'b00;
    back   = state_q == CHANGE ? (ge2 ? 2'b10 : 2'b01) : 2'b00;
    reject = reject_q;
    busy   = state_q != IDLE;
    credit = credit_q;
    for (int i = 0; i < 4; i++) sold_out[i] = stock_q[i] == '0;
  end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed and random checks of two vend_ctrl configurations against a behavioural model
module tb_vend_ctrl;
  localparam logic [5:0] N = 6'h00, C1 = 6'h01, C2 = 6'h02, CX = 6'h03;
  localparam logic [5:0] B0 = 6'h10, B1 = 6'h14, B2 = 6'h18, B3 = 6'h1C, RS = 6'h20;
  logic clk, reset, buy, restock;
  logic [1:0] coin, sel;
  logic drink0, reject0, busy0, drink1, reject1, busy1;
  logic [1:0] item0, back0, item1, back1;
  logic [5:0] credit0;
  logic [2:0] credit1;
  logic [3:0] sold0, sold1;
  int tests = 0, fails = 0;
  int cmax [2] = '{63, 7};
  int sinit [2] = '{8, 1};
  int pr [4] = '{3, 4, 5, 6};
  int m_credit [2];
  int m_stock [2][4];
  int m_vend [2];
  int m_item [2];
  int m_ref [2];
  int m_rej [2];

  vend_ctrl u0 (
    .clk(clk), .reset(reset), .coin(coin), .sel(sel), .buy(buy), .restock(restock),
    .drink(drink0), .item(item0), .back(back0), .reject(reject0), .busy(busy0),
    .credit(credit0), .sold_out(sold0)
  );
  vend_ctrl #(.CREDIT_W(3), .STOCK_INIT(1)) u1 (
    .clk(clk), .reset(reset), .coin(coin), .sel(sel), .buy(buy), .restock(restock),
    .drink(drink1), .item(item1), .back(back1), .reject(reject1), .busy(busy1),
    .credit(credit1), .sold_out(sold1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_credit[k] = 0; m_vend[k] = 0; m_item[k] = 0; m_ref[k] = 0; m_rej[k] = 0;
      for (int j = 0; j < 4; j++) m_stock[k][j] = sinit[k];
    end
  endtask

  // Purchase/refund rules applied to one machine at a clock edge
  task automatic model_edge(input int k, input logic [5:0] s);
    int c, sl, nr;
    c = int'(s[1:0]); sl = int'(s[3:2]); nr = 0;
    if (m_vend[k] != 0 || m_ref[k] != 0) begin
      nr = int'(c != 0);
      if (m_vend[k] != 0) m_vend[k] = 0;
      else m_credit[k] -= (m_credit[k] >= 2) ? 2 : 1;
      m_ref[k] = int'(m_credit[k] > 0);
    end else if (c == 3) begin
      m_ref[k] = int'(m_credit[k] > 0);
    end else if (c != 0) begin
      if (m_credit[k] + c > cmax[k]) nr = 1;
      else m_credit[k] += c;
    end else if (s[4]) begin
      if (m_credit[k] >= pr[sl] && m_stock[k][sl] > 0) begin
        m_credit[k] -= pr[sl]; m_stock[k][sl]--; m_vend[k] = 1; m_item[k] = sl;
      end else nr = 1;
    end
    if (s[5]) for (int j = 0; j < 4; j++) m_stock[k][j] = sinit[k];
    m_rej[k] = nr;
  endtask

  function automatic logic [18:0] expv(input int k);
    logic [3:0] so;
    int b;
    for (int j = 0; j < 4; j++) so[j] = m_stock[k][j] == 0;
    b = m_ref[k] != 0 ? (m_credit[k] >= 2 ? 2 : 1) : 0;
    return {m_vend[k] != 0, 2'(m_vend[k] != 0 ? m_item[k] : 0), 2'(b), m_rej[k] != 0,
            (m_vend[k] | m_ref[k]) != 0, 8'(m_credit[k]), so};
  endfunction

  function automatic logic [18:0] obs(input int k);
    return k == 0 ? {drink0, item0, back0, reject0, busy0, 8'(credit0), sold0}
                  : {drink1, item1, back1, reject1, busy1, 8'(credit1), sold1};
  endfunction

  task automatic step(input logic [5:0] s);
    coin = s[1:0]; sel = s[3:2]; buy = s[4]; restock = s[5];
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, s);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; coin = 2'b00; sel = 2'b00; buy = 1'b0; restock = 1'b0;
    #2;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin
        fails++; $display("FAIL reset dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin
        fails++; $display("FAIL reset_held dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_basic_purchase();
    logic [5:0] t[$];
    t = '{C1, C2, B0, N, N};
    do_reset();
    foreach (t[j]) begin
      step(t[j]);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin
          fails++; $display("FAIL basic step%0d dut%0d got %h want %h", j, k, obs(k), expv(k));
        end
      end
      if (j == 2) begin
        tests++;
        if ({drink0, item0, back0, busy0} !== 6'b1_00_00_1) begin
          fails++; $display("FAIL basic_latency got %b want 100001", {drink0, item0, back0, busy0});
        end
      end
    end
  endtask

  task automatic test_change();
    logic [5:0] t[$];
    t = '{C2, C2, C2, C1, B2, N, N, N};
    do_reset();
    foreach (t[j]) begin
      step(t[j]);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin
          fails++; $display("FAIL change step%0d dut%0d got %h want %h", j, k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_refund_and_reject();
    logic [5:0] t[$];
    t = '{C2, C1, CX, N, N, N, C2, B1, N, N};
    do_reset();
    foreach (t[j]) begin
      step(t[j]);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin
          fails++; $display("FAIL refund step%0d dut%0d got %h want %h", j, k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_sold_out();
    logic [5:0] t[$];
    t = '{C2, C2, C2, B3, N, C2, C2, C2, B3, N, N, N, N, RS, N};
    do_reset();
    foreach (t[j]) begin
      step(t[j]);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin
          fails++; $display("FAIL sold_out step%0d dut%0d got %h want %h", j, k, obs(k), expv(k));
        end
      end
      if (j == 9) begin
        tests++;
        if (sold1 !== 4'b1000) begin
          fails++; $display("FAIL sold_out_flag got %b want 1000", sold1);
        end
      end
    end
    tests++;
    if (sold1 !== 4'b0000) begin
      fails++; $display("FAIL restock_flag got %b want 0000", sold1);
    end
  endtask

  task automatic test_overflow_and_busy_coin();
    logic [5:0] t[$];
    t = '{C2, C2, C2, C1, C1, N, CX, C2, C2, N, N, N, N, N};
    do_reset();
    foreach (t[j]) begin
      step(t[j]);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin
          fails++; $display("FAIL overflow step%0d dut%0d got %h want %h", j, k, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] t[$];
    t = '{C2, C2, C2, CX, N};
    do_reset();
    foreach (t[j]) step(t[j]);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin
        fails++; $display("FAIL async_reset dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    tests++;
    if ({back0, busy0, credit0} !== 9'd0) begin
      fails++; $display("FAIL async_reset_now got %b want 0", {back0, busy0, credit0});
    end
    #1;
    reset = 1'b0;
    step(N);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== expv(k)) begin
        fails++; $display("FAIL after_reset dut%0d got %h want %h", k, obs(k), expv(k));
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] s;
    int r;
    do_reset();
    for (int j = 0; j < 800; j++) begin
      r = int'($urandom_range(0, 11));
      s[1:0] = r < 3 ? 2'b01 : r < 5 ? 2'b10 : r == 5 ? 2'b11 : 2'b00;
      s[3:2] = 2'($urandom_range(0, 3));
      s[4] = 1'($urandom_range(0, 1));
      s[5] = $urandom_range(0, 49) == 0;
      step(s);
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expv(k)) begin
          fails++; $display("FAIL random step%0d dut%0d in %h got %h want %h", j, k, s, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_purchase();
    test_change();
    test_refund_and_reject();
    test_sold_out();
    test_overflow_and_busy_coin();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
